cpu_mem_ctrl: RTL and testbench

Parametrised dual-port memory controller for the CPU core, the successor to the fixed 11-bit/32-bit dual-port RAM hookup.
- Port I: read-only instruction fetch, driven by the PC.
- Port D: read/write load/store port with byte enables.
- Adds a configurable read-latency pipeline, valid/ready request handshakes, a post-reset zero-fill init sequence, and defined same-cycle collision behaviour.
- Sits between the cpu and the memory array and replaces the bare RAM instance at top level.

---
 rtl/cpu_mem_ctrl.sv | 136 +++++++++++++
 tb/tb_cpu_mem_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_ctrl.sv
// Dual-port CPU memory controller: instruction fetch port I, load/store port D with byte enables,
// configurable read latency, post-reset zero-fill and write-first I/D collision handling.

module cpu_mem_rd_pipe #(
    parameter int LAT = 1,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [LAT-1:0] vld;
    logic [W-1:0]   dat [LAT];

    // Data stages load only behind a valid beat, so the last stage holds the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < LAT; k++) dat[k] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
            for (int k = 1; k < LAT; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) dat[k] <= dat[k-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];
endmodule

module cpu_mem_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                init_done
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W/8;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              run;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              i_acc, d_rd, d_wr;
    logic [DATA_W-1:0] wr_word, i_word, d_word;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_word;
        for (int k = 0; k < BE_W; k++)
            if (be[k]) r[8*k +: 8] = new_word[8*k +: 8];
        return r;
    endfunction

    // run is the registered image of the RUN state; it drives all three status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= S_RUN;
                        run   <= 1'b1;
                    end
                end
                default: run <= 1'b1;
            endcase
        end
    end

    assign i_ready   = run;
    assign d_ready   = run;
    assign init_done = run;

    assign i_acc = i_req & run;
    assign d_wr  = d_req & run & d_we;
    assign d_rd  = d_req & run & ~d_we;

    // NOTE: always_comb uses blocking assignments and gives every output a value on every path.
    always_comb begin
        wr_word = merge_bytes(mem[d_addr], d_wdata, d_be);
        d_word  = mem[d_addr];
        i_word  = mem[i_addr];
        if (d_wr && (d_addr == i_addr)) i_word = wr_word;
    end

    // NOTE: the array has no reset; contents survive rst_n and are cleared only by the INIT sweep.
    always_ff @(posedge clk) begin
        if (state == S_INIT)
            mem[cnt] <= '0;
        else if (d_wr)
            mem[d_addr] <= wr_word;
    end

    cpu_mem_rd_pipe #(.LAT(RD_LAT), .W(DATA_W)) u_i_pipe (
        .clk(clk), .rst_n(rst_n), .in_valid(i_acc), .in_data(i_word),
        .out_valid(i_rvalid), .out_data(i_rdata)
    );

    cpu_mem_rd_pipe #(.LAT(RD_LAT), .W(DATA_W)) u_d_pipe (
        .clk(clk), .rst_n(rst_n), .in_valid(d_rd), .in_data(d_word),
        .out_valid(d_rvalid), .out_data(d_rdata)
    );
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Directed bench for cpu_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=3, 16 words) share one
// stimulus stream; a vector table covers single-cycle behaviour, hand sequences the multi-cycle cases.

module tb_cpu_mem_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [3:0]    d_be;
    logic [DW-1:0] d_wdata;

    logic          i_ready_a, i_rvalid_a, d_ready_a, d_rvalid_a, init_done_a;
    logic [DW-1:0] i_rdata_a, d_rdata_a;
    logic          i_ready_b, i_rvalid_b, d_ready_b, d_rvalid_b, init_done_b;
    logic [DW-1:0] i_rdata_b, d_rdata_b;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    cpu_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .INIT_ZERO(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_a), .i_rvalid(i_rvalid_a), .i_rdata(i_rdata_a),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a), .init_done(init_done_a)
    );

    cpu_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .INIT_ZERO(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_b), .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b), .init_done(init_done_b)
    );

    typedef struct {
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_req;
        logic          d_we;
        logic [3:0]    d_be;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic          e_irv;
        logic [DW-1:0] e_ird;
        logic          e_drv;
        logic [DW-1:0] e_drd;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic apply(input vec_t v);
        i_req = v.i_req; i_addr = v.i_addr;
        d_req = v.d_req; d_we = v.d_we; d_be = v.d_be; d_addr = v.d_addr; d_wdata = v.d_wdata;
    endtask

    task automatic check_zero(input string name);
        check({name, "_a"}, 96'({i_ready_a, i_rvalid_a, i_rdata_a, d_ready_a, d_rvalid_a, d_rdata_a, init_done_a}), 96'(0));
        check({name, "_b"}, 96'({i_ready_b, i_rvalid_b, i_rdata_b, d_ready_b, d_rvalid_b, d_rdata_b, init_done_b}), 96'(0));
    endtask

    // Counts rising edges after reset release until init_done; -1 if it never comes.
    task automatic wait_init(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (init_done_a) begin
                cycles = c;
                break;
            end
            check("quiet_during_init", 96'({i_ready_a, d_ready_a, i_ready_b, d_ready_b, init_done_b,
                                            i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b}), 96'(0));
        end
    endtask

    initial begin
        //          i_req i_addr d_req d_we d_be   d_addr d_wdata        e_irv e_ird          e_drv e_drd
        vecs[0]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 4'h7, 32'h11223344, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 4'h7, 32'hAABBCCDD, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
        vecs[2]  = '{1'b1, 4'h7, 1'b1, 1'b0, 4'h0, 4'h7, 32'h00000000, 1'b1, 32'h11BB33DD, 1'b1, 32'h11BB33DD};
        vecs[3]  = '{1'b1, 4'h9, 1'b1, 1'b1, 4'hF, 4'h9, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0, 32'h11BB33DD};
        vecs[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0, 32'hCAFEF00D, 1'b0, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 4'h9, 1'b1, 1'b1, 4'h0, 4'h9, 32'hFFFFFFFF, 1'b1, 32'hCAFEF00D, 1'b0, 32'h11BB33DD};
        vecs[6]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'hF, 4'h9, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 4'h3, 1'b1, 1'b1, 4'h1, 4'h3, 32'h00000055, 1'b1, 32'h00000055, 1'b0, 32'hCAFEF00D};
        vecs[8]  = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 4'h3, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 32'h00000055};
        vecs[9]  = '{1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 4'hF, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 32'h00000055};
        vecs[10] = '{1'b1, 4'h7, 1'b1, 1'b0, 4'h0, 4'hF, 32'h00000000, 1'b1, 32'h11BB33DD, 1'b1, 32'h12345678};

        // Power-up reset and zero-fill.
        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        #1 check_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1 check_zero("reset_held");
        @(negedge clk) rst_n = 1'b1;
        wait_init(n);
        check("init_cycles", 96'(n), 96'(16));
        check("ready_after_init", 96'({i_ready_a, d_ready_a, init_done_a, i_ready_b, d_ready_b, init_done_b}), 96'(6'h3F));

        // Single-cycle behaviour on the RD_LAT=1 instance.
        for (int v = 0; v < 11; v++) begin
            apply(vecs[v]);
            @(posedge clk); #1;
            check($sformatf("v%0d_i_rvalid", v), 96'(i_rvalid_a), 96'(vecs[v].e_irv));
            check($sformatf("v%0d_i_rdata", v),  96'(i_rdata_a),  96'(vecs[v].e_ird));
            check($sformatf("v%0d_d_rvalid", v), 96'(d_rvalid_a), 96'(vecs[v].e_drv));
            check($sformatf("v%0d_d_rdata", v),  96'(d_rdata_a),  96'(vecs[v].e_drd));
        end

        // Back-to-back reads through the RD_LAT=3 pipeline.
        idle();
        repeat (4) @(posedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 4'h5; d_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        for (int j = 1; j <= 8; j++) begin
            idle();
            if (j <= 4) begin
                i_req = 1'b1; i_addr = 4'h5;
            end
            @(posedge clk); #1;
            check($sformatf("lat3_rvalid_e%0d", j), 96'(i_rvalid_b), 96'((j >= 3) && (j <= 6)));
            check($sformatf("lat1_rvalid_e%0d", j), 96'(i_rvalid_a), 96'(j <= 4));
            if (j >= 3) check($sformatf("lat3_rdata_e%0d", j), 96'(i_rdata_b), 96'(32'hDEADBEEF));
        end
        check("lat3_no_d_rvalid", 96'(d_rvalid_b), 96'(0));

        // Reset with reads in flight, then reset again mid-INIT at cnt = 7.
        idle();
        i_req = 1'b1; i_addr = 4'h5; d_req = 1'b1; d_addr = 4'h7;
        @(posedge clk); #1;
        idle();
        check("inflight_pending", 96'({i_rvalid_b, d_rvalid_b}), 96'(0));
        #2 rst_n = 1'b0;
        #1 check_zero("reset_inflight");
        @(negedge clk) rst_n = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk); #1;
            check($sformatf("no_stale_rvalid_e%0d", j), 96'({i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b, init_done_a}), 96'(0));
        end
        #2 rst_n = 1'b0;
        #1 check_zero("reset_mid_init");
        @(posedge clk); #1;
        check_zero("reset_mid_init_held");
        @(negedge clk) rst_n = 1'b1;
        wait_init(n);
        check("reinit_cycles", 96'(n), 96'(16));
        @(posedge clk); #1;
        check("idle_after_reinit", 96'({i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b}), 96'(0));

        // Re-init wiped the array: address 5 and top address 0xF read back zero.
        i_req = 1'b1; i_addr = 4'h5; d_req = 1'b1; d_we = 1'b0; d_addr = 4'hF;
        @(posedge clk); #1;
        idle();
        check("post_reinit_i", 96'({i_rvalid_a, i_rdata_a}), 96'({1'b1, 32'h0}));
        check("post_reinit_d", 96'({d_rvalid_a, d_rdata_a}), 96'({1'b1, 32'h0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
